// File: rtl/shift_adder_sched.sv
// Round-robin scheduler feeding one shared segmented, registered-carry adder.
// Operands are held for the full carry-settle time, then the sum goes out on a valid/ready channel.
module shift_adder_sched #(
    parameter  int W   = 16,
    parameter  int N   = 4,
    parameter  int R   = 4,
    localparam int IDW = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [R*W-1:0]   req_a,
    input  logic [R*W-1:0]   req_b,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    input  logic [W-1:0]     add_sum,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [W-1:0]     rsp_sum,
    output logic             busy
);
    localparam int S  = W / N;
    localparam int CW = $clog2(S + 1);

    if (W % N != 0) begin : g_bad_w
        $error("shift_adder_sched: W must be a multiple of N");
    end
    if (R < 2 || R > 16) begin : g_bad_r
        $error("shift_adder_sched: R must be in 2..16");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id_q;
    logic [CW-1:0]  cnt;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;

    // First valid requester at or above the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < R; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr) + k) % R]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(rr_ptr) + k) % R);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready = R'(1) << grant_idx;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: if (cnt == CW'(S)) state_nxt = RESP;
            RESP:   if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        add_a  <= req_a[int'(grant_idx)*W +: W];
                        add_b  <= req_b[int'(grant_idx)*W +: W];
                        id_q   <= grant_idx;
                        rr_ptr <= (grant_idx == IDW'(R - 1)) ? '0 : grant_idx + IDW'(1);
                        cnt    <= '0;
                    end
                end
                SETTLE: begin
                    // Sum register is complete one edge before this capture; operands stay put meanwhile.
                    if (cnt == CW'(S)) begin
                        rsp_sum   <= add_sum;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_adder_sched.sv
// Directed bench for shift_adder_sched with a behavioural segmented registered-carry adder.
module tb_shift_adder_sched;
    localparam int W   = 16;
    localparam int N   = 4;
    localparam int R   = 4;
    localparam int IDW = 2;
    localparam int S   = W / N;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [R-1:0]   req_valid = '0;
    logic [R-1:0]   req_ready;
    logic [R*W-1:0] req_a = '0;
    logic [R*W-1:0] req_b = '0;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           busy;

    int total = 0;
    int bad   = 0;

    shift_adder_sched #(.W(W), .N(N), .R(R)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
    );

    always #5 clk = ~clk;

    // External adder: one carry hop per segment per clock, no reset.
    logic [S-1:0] cy;
    always @(posedge clk) begin : adder_model
        logic [N:0] t;
        logic [S:0] cin;
        cin = {cy, 1'b0};
        for (int s = 0; s < S; s++) begin
            t = {1'b0, add_a[s*N +: N]} + {1'b0, add_b[s*N +: N]} + {{N{1'b0}}, cin[s]};
            add_sum[s*N +: N] <= t[N-1:0];
            cy[s] <= t[N];
        end
    end

    // Operands must not move while settling (busy and no response pending).
    logic [W-1:0] prev_a, prev_b;
    logic         prev_settle = 1'b0;
    always @(negedge clk) begin
        if (rst_n && busy && !rsp_valid && prev_settle) begin
            total++;
            if (add_a !== prev_a || add_b !== prev_b) begin
                bad++;
                $display("FAIL settle_hold: add_a=%h add_b=%h was %h %h", add_a, add_b, prev_a, prev_b);
            end
        end
        prev_a      = add_a;
        prev_b      = add_b;
        prev_settle = rst_n && busy && !rsp_valid;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present a request and hold it until accepted; returns just after the grant edge.
    task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid[idx] = 1'b1;
        ok = 1'b0;
        #1;
        for (int t = 0; t < 64; t++) begin
            if (req_ready[idx]) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid[idx] = 1'b0;
    endtask

    task automatic collect(output logic [W-1:0] sum, output logic [IDW-1:0] id, output bit ok);
        ok = 1'b0; sum = '0; id = '0;
        for (int t = 0; t < 64; t++) begin
            if (rsp_valid) begin
                sum = rsp_sum; id = rsp_id;
                rsp_ready = 1'b1;
                @(posedge clk); #1;
                rsp_ready = 1'b0;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (add_a !== '0 || add_b !== '0) begin bad++; $display("FAIL reset_operands: got %h %h want 0 0", add_a, add_b); end
        total++; if (rsp_id !== '0 || rsp_sum !== '0) begin bad++; $display("FAIL reset_rsp: got id=%0d sum=%h want 0 0", rsp_id, rsp_sum); end
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        req_a[0 +: W] = 16'h1234;
        req_b[0 +: W] = 16'h0101;
        req_valid[0] = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL basic_ready: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL basic_ready_drop: got %b want 0000", req_ready); end
        total++; if (busy !== 1'b1 || add_a !== 16'h1234 || add_b !== 16'h0101) begin
            bad++; $display("FAIL basic_launch: busy=%b a=%h b=%h want 1 1234 0101", busy, add_a, add_b); end
        for (int k = 1; k <= S; k++) begin
            @(posedge clk); #1;
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_early: rsp_valid=1 at grant+%0d want 0", k); end
        end
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL basic_latency: rsp_valid=%b at grant+%0d want 1", rsp_valid, S+1); end
        total++; if (rsp_sum !== 16'h1335 || rsp_id !== 2'd0) begin
            bad++; $display("FAIL basic_result: sum=%h id=%0d want 1335 0", rsp_sum, rsp_id); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_handshake: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_carry();
        logic [W-1:0] a_v [4] = '{16'hFFFF, 16'h0FFF, 16'hFFFF, 16'h0000};
        logic [W-1:0] b_v [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000};
        logic [W-1:0] e_v [4] = '{16'h0000, 16'h1000, 16'h0000, 16'h0000};
        logic [W-1:0] sum;
        logic [IDW-1:0] id;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            issue(0, a_v[i], b_v[i], ok);
            total++; if (!ok) begin bad++; $display("FAIL carry_grant%0d: no grant want grant", i); end
            collect(sum, id, ok);
            total++; if (!ok || sum !== e_v[i]) begin
                bad++; $display("FAIL carry_sum%0d: got %h (ok=%0d) want %h", i, sum, ok, e_v[i]); end
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] sum;
        logic [IDW-1:0] id;
        bit ok, got;
        logic [W-1:0] exp [4] = '{16'h0011, 16'h1012, 16'h2013, 16'h3014};
        do_reset();
        for (int i = 0; i < R; i++) begin
            req_a[i*W +: W] = W'(16'h1000 * i + 16'h0011);
            req_b[i*W +: W] = W'(i);
        end
        req_valid = '1;
        #1;
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            for (int t = 0; t < 32 && !got; t++) begin
                if (req_ready != '0) got = 1'b1;
                else begin @(posedge clk); #1; end
            end
            total++; if (req_ready !== (4'b0001 << (g % R)) || busy !== 1'b0) begin
                bad++; $display("FAIL rr_grant%0d: ready=%b busy=%b want %b 0", g, req_ready, busy, 4'b0001 << (g % R)); end
            @(posedge clk); #1;
            collect(sum, id, ok);
            total++; if (!ok || id !== IDW'(g % R) || sum !== exp[g % R]) begin
                bad++; $display("FAIL rr_rsp%0d: id=%0d sum=%h ok=%0d want %0d %h", g, id, sum, ok, g % R, exp[g % R]); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] sum;
        logic [IDW-1:0] id;
        bit ok, got;
        do_reset();
        req_a[0 +: W] = 16'h00F0; req_b[0 +: W] = 16'h0F10;
        req_a[W +: W] = 16'h8000; req_b[W +: W] = 16'h8001;
        req_valid = 4'b0011;
        #1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 32 && !got; t++) begin
            if (rsp_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        total++; if (!got || rsp_sum !== 16'h1000 || rsp_id !== 2'd0) begin
            bad++; $display("FAIL bp_first: got=%0d sum=%h id=%0d want 1 1000 0", got, rsp_sum, rsp_id); end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            total++; if (rsp_valid !== 1'b1 || rsp_sum !== 16'h1000 || rsp_id !== 2'd0 || req_ready !== '0) begin
                bad++; $display("FAIL bp_hold%0d: valid=%b sum=%h id=%0d ready=%b want 1 1000 0 0000", k, rsp_valid, rsp_sum, rsp_id, req_ready); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
            bad++; $display("FAIL bp_release: valid=%b ready=%b want 0 0010", rsp_valid, req_ready); end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        total++; if (busy !== 1'b1 || add_a !== 16'h8000 || add_b !== 16'h8001) begin
            bad++; $display("FAIL bp_next_grant: busy=%b a=%h b=%h want 1 8000 8001", busy, add_a, add_b); end
        collect(sum, id, ok);
        total++; if (!ok || sum !== 16'h0001 || id !== 2'd1) begin
            bad++; $display("FAIL bp_second: sum=%h id=%0d ok=%0d want 0001 1", sum, id, ok); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        issue(2, 16'hABCD, 16'h1111, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_mid_grant: no grant want grant"); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || add_a !== '0 || add_b !== '0) begin
            bad++; $display("FAIL rst_mid_clear: valid=%b busy=%b a=%h b=%h want 0 0 0 0", rsp_valid, busy, add_a, add_b); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (S + 3) begin
            @(posedge clk); #1;
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_ghost: rsp_valid=1 want 0"); end
        end
        issue(3, 16'h00FF, 16'h0001, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_mid_regrant: no grant want grant"); end
        repeat (S) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_early: rsp_valid=1 want 0"); end
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0100 || rsp_id !== 2'd3) begin
            bad++; $display("FAIL rst_mid_result: valid=%b sum=%h id=%0d want 1 0100 3", rsp_valid, rsp_sum, rsp_id); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish want finish");
        $fatal(1, "watchdog");
    end
endmodule
